// File: rtl/cmd_decoder.sv
// Command byte decoder: reads bytes from the shared command register and
// turns them into colour/border/mode register writes and palette RAM writes.
module cmd_decoder #(
  parameter int ERR_CNT_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    has_data,
  input  logic [7:0]              rd_data,
  output logic                    rd,
  output logic [3:0]              red,
  output logic [3:0]              green,
  output logic [3:0]              blue,
  output logic [3:0]              border,
  output logic [1:0]              mode,
  output logic                    pal_wr,
  output logic [3:0]              pal_idx,
  output logic [11:0]             pal_data,
  output logic                    busy,
  output logic [ERR_CNT_BITS-1:0] err_count
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACK      = 2'd1,
    ST_WAIT_CLR = 2'd2
  } state_t;

  localparam logic [ERR_CNT_BITS-1:0] ERR_ONE = {{(ERR_CNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [ERR_CNT_BITS-1:0] ERR_MAX = {ERR_CNT_BITS{1'b1}};

  state_t                  state_reg, state_next;
  logic [7:0]              byte_reg, byte_next;
  logic [1:0]              phase_reg, phase_next;
  logic [3:0]              pend_idx_reg, pend_idx_next;
  logic [3:0]              pend_red_reg, pend_red_next;
  logic [3:0]              chan_reg [4];
  logic [3:0]              chan_next [4];
  logic [1:0]              mode_reg, mode_next;
  logic                    pal_wr_reg, pal_wr_next;
  logic [3:0]              pal_idx_reg, pal_idx_next;
  logic [11:0]             pal_data_reg, pal_data_next;
  logic                    busy_reg, busy_next;
  logic [ERR_CNT_BITS-1:0] err_reg, err_next;
  logic                    rd_reg, rd_next;
  logic                    chan_wr;
  logic [1:0]              chan_sel;

  // Channel index order: 0 blue, 1 green, 2 red, 3 border.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
      assign chan_next[gi] = (chan_wr && (chan_sel == 2'(gi))) ? byte_reg[3:0] : chan_reg[gi];
    end
  endgenerate

  // Handshake FSM and byte parser: next-state and next register values.
  always_comb begin
    state_next    = state_reg;
    byte_next     = byte_reg;
    phase_next    = phase_reg;
    pend_idx_next = pend_idx_reg;
    pend_red_next = pend_red_reg;
    mode_next     = mode_reg;
    pal_wr_next   = 1'b0;
    pal_idx_next  = pal_idx_reg;
    pal_data_next = pal_data_reg;
    err_next      = err_reg;
    rd_next       = 1'b0;
    chan_wr       = 1'b0;
    chan_sel      = byte_reg[5:4];
    case (state_reg)
      ST_IDLE: begin
        if (has_data) begin
          byte_next  = rd_data;
          rd_next    = 1'b1;
          state_next = ST_ACK;
        end
      end
      ST_ACK: begin
        state_next = ST_WAIT_CLR;
        case (phase_reg)
          2'd0: begin
            case (byte_reg[7:6])
              2'b00: chan_wr = 1'b1;
              2'b01: begin
                pend_idx_next = byte_reg[3:0];
                phase_next    = 2'd1;
              end
              2'b10: mode_next = byte_reg[1:0];
              default: begin
                if (err_reg != ERR_MAX) err_next = err_reg + ERR_ONE;
              end
            endcase
          end
          2'd1: begin
            pend_red_next = byte_reg[3:0];
            phase_next    = 2'd2;
          end
          2'd2: begin
            pal_idx_next  = pend_idx_reg;
            pal_data_next = {pend_red_reg, byte_reg};
            pal_wr_next   = 1'b1;
            phase_next    = 2'd0;
          end
          default: phase_next = 2'd0;
        endcase
      end
      ST_WAIT_CLR: begin
        // Wait for the producer to drop has_data so one byte is never read twice.
        if (!has_data) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    busy_next = (phase_next != 2'd0);
  end

  // State and output registers; reset discards any partial palette command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      byte_reg     <= '0;
      phase_reg    <= '0;
      pend_idx_reg <= '0;
      pend_red_reg <= '0;
      for (int i = 0; i < 4; i++) chan_reg[i] <= '0;
      mode_reg     <= '0;
      pal_wr_reg   <= 1'b0;
      pal_idx_reg  <= '0;
      pal_data_reg <= '0;
      busy_reg     <= 1'b0;
      err_reg      <= '0;
      rd_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      byte_reg     <= byte_next;
      phase_reg    <= phase_next;
      pend_idx_reg <= pend_idx_next;
      pend_red_reg <= pend_red_next;
      for (int i = 0; i < 4; i++) chan_reg[i] <= chan_next[i];
      mode_reg     <= mode_next;
      pal_wr_reg   <= pal_wr_next;
      pal_idx_reg  <= pal_idx_next;
      pal_data_reg <= pal_data_next;
      busy_reg     <= busy_next;
      err_reg      <= err_next;
      rd_reg       <= rd_next;
    end
  end

  assign rd        = rd_reg;
  assign blue      = chan_reg[0];
  assign green     = chan_reg[1];
  assign red       = chan_reg[2];
  assign border    = chan_reg[3];
  assign mode      = mode_reg;
  assign pal_wr    = pal_wr_reg;
  assign pal_idx   = pal_idx_reg;
  assign pal_data  = pal_data_reg;
  assign busy      = busy_reg;
  assign err_count = err_reg;

endmodule

// File: tb/tb_cmd_decoder.sv
// Self-checking bench for cmd_decoder: directed table, corner sequences and
// randomized bytes against a queue-based command model.
module tb_cmd_decoder;

  logic        clk;
  logic        rst;
  logic        has_data;
  logic [7:0]  rd_data;
  logic        rd;
  logic [3:0]  red, green, blue, border;
  logic [1:0]  mode;
  logic        pal_wr;
  logic [3:0]  pal_idx;
  logic [11:0] pal_data;
  logic        busy;
  logic [7:0]  err_count;

  cmd_decoder #(.ERR_CNT_BITS(8)) dut (
    .clk(clk), .rst(rst), .has_data(has_data), .rd_data(rd_data), .rd(rd),
    .red(red), .green(green), .blue(blue), .border(border), .mode(mode),
    .pal_wr(pal_wr), .pal_idx(pal_idx), .pal_data(pal_data), .busy(busy),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a palette command is the queue of bytes received so far.
  logic [3:0]  m_red, m_green, m_blue, m_border, m_idx;
  logic [1:0]  m_mode;
  logic [11:0] m_data;
  logic        m_pal_wr;
  int          m_err;
  logic [7:0]  pend_q[$];
  logic        last_pal_wr;

  typedef struct {
    logic [7:0]  b;
    logic [3:0]  r, g, bl, bd;
    logic [1:0]  md;
    logic        bsy, pw;
    logic [3:0]  idx;
    logic [11:0] data;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_red = 0; m_green = 0; m_blue = 0; m_border = 0; m_mode = 0;
    m_idx = 0; m_data = 0; m_pal_wr = 0; m_err = 0;
    pend_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    m_pal_wr = 1'b0;
    if (pend_q.size() == 0) begin
      case (b[7:6])
        2'b00: case (b[5:4])
                 2'd0: m_blue   = b[3:0];
                 2'd1: m_green  = b[3:0];
                 2'd2: m_red    = b[3:0];
                 default: m_border = b[3:0];
               endcase
        2'b01: pend_q.push_back(b);
        2'b10: m_mode = b[1:0];
        default: if (m_err < 255) m_err++;
      endcase
    end else if (pend_q.size() == 1) begin
      pend_q.push_back(b);
    end else begin
      m_idx    = pend_q[0][3:0];
      m_data   = {pend_q[1][3:0], b};
      m_pal_wr = 1'b1;
      pend_q.delete();
    end
  endtask

  task automatic chk_all();
    chk("red", red, m_red);
    chk("green", green, m_green);
    chk("blue", blue, m_blue);
    chk("border", border, m_border);
    chk("mode", mode, m_mode);
    chk("busy", busy, pend_q.size() != 0);
    chk("pal_idx", pal_idx, m_idx);
    chk("pal_data", pal_data, m_data);
    chk("err_count", err_count, m_err);
    chk("pal_wr", last_pal_wr, m_pal_wr);
  endtask

  // Present one byte, wait (bounded) for rd, drop has_data, then check.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    has_data = 1'b1;
    rd_data  = b;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd) begin ok = 1'b1; break; end
    end
    chk("rd_handshake", ok, 1);
    has_data = 1'b0;
    @(negedge clk);
    chk("rd_single_cycle", rd, 0);
    last_pal_wr = pal_wr;
    if (ok) model_byte(b);
    chk_all();
    @(negedge clk);
    chk("pal_wr_single_cycle", pal_wr, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    has_data = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    last_pal_wr = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [7:0] rb;

    vecs[0] = '{8'h2A, 4'hA, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 4'h0, 12'h000};
    vecs[1] = '{8'h15, 4'hA, 4'h5, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 4'h0, 12'h000};
    vecs[2] = '{8'h07, 4'hA, 4'h5, 4'h7, 4'h0, 2'd0, 1'b0, 1'b0, 4'h0, 12'h000};
    vecs[3] = '{8'h39, 4'hA, 4'h5, 4'h7, 4'h9, 2'd0, 1'b0, 1'b0, 4'h0, 12'h000};
    vecs[4] = '{8'h43, 4'hA, 4'h5, 4'h7, 4'h9, 2'd0, 1'b1, 1'b0, 4'h0, 12'h000};
    vecs[5] = '{8'h0C, 4'hA, 4'h5, 4'h7, 4'h9, 2'd0, 1'b1, 1'b0, 4'h0, 12'h000};
    vecs[6] = '{8'h5E, 4'hA, 4'h5, 4'h7, 4'h9, 2'd0, 1'b0, 1'b1, 4'h3, 12'hC5E};
    vecs[7] = '{8'h41, 4'hA, 4'h5, 4'h7, 4'h9, 2'd0, 1'b1, 1'b0, 4'h3, 12'hC5E};
    vecs[8] = '{8'hFF, 4'hA, 4'h5, 4'h7, 4'h9, 2'd0, 1'b1, 1'b0, 4'h3, 12'hC5E};
    vecs[9] = '{8'hFF, 4'hA, 4'h5, 4'h7, 4'h9, 2'd0, 1'b0, 1'b1, 4'h1, 12'hFFF};

    rst = 1'b1;
    has_data = 1'b0;
    rd_data = 8'h00;
    model_reset();
    last_pal_wr = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_rd", rd, 0);
    chk("reset_pal_wr", pal_wr, 0);
    chk("reset_busy", busy, 0);
    chk("reset_outputs", {red, green, blue, border, mode, pal_idx, pal_data, err_count}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table: channels, palette write, data bytes that look like reserved opcodes.
    for (int i = 0; i < 10; i++) begin
      send_byte(vecs[i].b);
      chk("tbl_red", red, vecs[i].r);
      chk("tbl_green", green, vecs[i].g);
      chk("tbl_blue", blue, vecs[i].bl);
      chk("tbl_border", border, vecs[i].bd);
      chk("tbl_mode", mode, vecs[i].md);
      chk("tbl_busy", busy, vecs[i].bsy);
      chk("tbl_pal_wr", last_pal_wr, vecs[i].pw);
      chk("tbl_pal_idx", pal_idx, vecs[i].idx);
      chk("tbl_pal_data", pal_data, vecs[i].data);
      chk("tbl_err", err_count, 0);
    end

    // has_data held high for 10 cycles: one read only until it drops and rises.
    cnt = 0;
    has_data = 1'b1;
    rd_data = 8'h81;
    repeat (10) begin
      @(negedge clk);
      if (rd) cnt++;
    end
    model_byte(8'h81);
    chk("hold_rd_count", cnt, 1);
    chk("hold_mode", mode, 1);
    has_data = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (rd) cnt++;
    end
    chk("hold_no_extra_rd", cnt, 1);
    has_data = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (rd) cnt++;
    end
    chk("hold_second_rd", cnt, 2);
    has_data = 1'b0;
    model_byte(8'h81);
    repeat (2) @(negedge clk);
    last_pal_wr = 1'b0;
    m_pal_wr = 1'b0;
    chk_all();

    // 300 reserved opcodes: counter saturates, nothing else moves.
    for (int i = 0; i < 300; i++) send_byte(8'hC0);
    chk("err_saturated", err_count, 255);
    chk("sat_red_kept", red, 4'hA);
    chk("sat_mode_kept", mode, 1);

    // Reset in the middle of a palette command discards it.
    send_byte(8'h42);
    send_byte(8'h08);
    chk("mid_busy_before_rst", busy, 1);
    do_reset();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_pal_wr", pal_wr, 0);
    chk("rst_err", err_count, 0);
    send_byte(8'h2F);
    chk("after_rst_red", red, 4'hF);
    chk("after_rst_pal_wr", last_pal_wr, 0);

    // Randomized bytes, palette-heavy, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      rb = 8'($urandom);
      if ($urandom_range(0, 2) == 0) rb[7:6] = 2'b01;
      send_byte(rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cmd_decoder.md
Name: cmd_decoder

Overview:
- Downstream consumer of the command shared register that the FIFO-read stage fills.
- Parses the byte stream into single-byte channel/mode commands and three-byte palette-write commands.
- Drives the colour channel registers, the display mode, and a write port into the palette RAM.
- Sits between the shared register and the pixel colour generator; it replaces the ad-hoc command processing loop.

Parameters:
- ERR_CNT_BITS, 8, width of the saturating unknown-opcode counter.

Ports:
- clk  in  1  system clock (PLL global buffer).
- rst  in  1  asynchronous active-high reset.
- has_data  in  1  shared register holds an unread byte.
- rd_data  in  8  shared register byte.
- rd  out  1  read acknowledge to shared register; one-cycle pulse.
- red  out  4  red channel value.
- green  out  4  green channel value.
- blue  out  4  blue channel value.
- border  out  4  border grey level.
- mode  out  2  display mode.
- pal_wr  out  1  palette write strobe; one-cycle pulse.
- pal_idx  out  4  palette write index.
- pal_data  out  12  palette write data {R,G,B}.
- busy  out  1  high while a multi-byte command is partially received.
- err_count  out  ERR_CNT_BITS  saturating count of reserved opcodes.

Behaviour:
- Reset (async, rst=1): all outputs 0; handshake FSM in IDLE; parse phase 0; internal byte latch 0.
- Handshake FSM:
  - IDLE: if has_data=1, latch rd_data, rd<=1, go to ACK.
  - ACK: rd<=0, execute parse step on latched byte, go to WAIT_CLR.
  - WAIT_CLR: stay until has_data=0, then go to IDLE. This guarantees a stale has_data never causes a double read.
- Throughput: at most one byte per 3 cycles.
- Latency: a byte sampled at edge N updates its outputs (and pulses pal_wr) at edge N+1.
- Parse phase 0, opcode = byte[7:6]:
  - 00 SET_CHAN: byte[5:4] selects the channel (0 blue, 1 green, 2 red, 3 border); byte[3:0] is the value. Phase stays 0.
  - 01 SET_PAL: store byte[3:0] as the pending index; phase<=1. byte[5:4] is ignored.
  - 10 SET_MODE: mode<=byte[1:0]; byte[5:2] is ignored.
  - 11 reserved: no state change; err_count += 1, saturating at all-ones.
- Parse phase 1: pending red <= byte[3:0]; byte[7:4] is ignored; phase<=2.
- Parse phase 2:
  - pal_idx <= pending index; pal_data <= {pending red, byte[7:4], byte[3:0]}; pal_wr=1 for exactly one cycle; phase<=0.
  - Data bytes in phases 1 and 2 are never decoded as opcodes, even 0xC0–0xFF.
- busy = (phase != 0), registered with phase.
- pal_idx and pal_data hold their last values between writes.
- Channel, border, and mode registers hold their values until rewritten.
- Reset mid-sequence: a partial palette command is discarded with no pal_wr, and phase returns to 0.
- has_data falling during ACK: legal; the FSM proceeds to WAIT_CLR and exits the following cycle.
- rd is never high in two consecutive cycles.

Test Plan:
- Reset, then bytes 0x2A, 0x15, 0x07, 0x39, each presented for one byte slot -> red=0xA, green=0x5, blue=0x7, border=0x9; 4 rd pulses; pal_wr never asserted.
- Bytes 0x43, 0x0C, 0x5E -> one pal_wr pulse one cycle after the third byte is latched, with pal_idx=3 and pal_data=0xC5E; busy high from the first byte until the third byte is consumed.
- Bytes 0x41, 0xFF, 0xFF -> pal_idx=1, pal_data=0xFFF, err_count unchanged (data bytes not decoded).
- 300 bytes of 0xC0 -> err_count=255 (saturated); all other outputs unchanged.
- Bytes 0x42, 0x08, then rst pulse, then 0x2F -> no pal_wr, busy=0 after reset, red=0xF.
- has_data held high for 10 cycles while presenting 0x81 -> exactly one rd pulse, mode=1; a second rd pulse occurs only after has_data falls and rises again.
